// File: rtl/multicycle_main_control_if.sv
// rtl/multicycle_main_control_if.sv - instruction/memory handshake and datapath-control bundle for the main control FSM
interface multicycle_main_control_if #(
    parameter int CNT_W = 16
);
    logic             i_start;
    logic [3:0]       i_opcode;
    logic             i_zero;
    logic             i_mem_ready;
    logic [1:0]       o_alu_op;
    logic [3:0]       o_alu_func;
    logic [1:0]       o_alu_src_b;
    logic             o_pc_write;
    logic             o_pc_src;
    logic             o_ir_write;
    logic             o_mem_read;
    logic             o_mem_write;
    logic             o_i_or_d;
    logic             o_reg_write;
    logic             o_mem_to_reg;
    logic             o_halted;
    logic             o_err;
    logic [CNT_W-1:0] o_retired;

    modport slave (
        input  i_start, i_opcode, i_zero, i_mem_ready,
        output o_alu_op, o_alu_func, o_alu_src_b, o_pc_write, o_pc_src,
               o_ir_write, o_mem_read, o_mem_write, o_i_or_d, o_reg_write,
               o_mem_to_reg, o_halted, o_err, o_retired
    );

    modport master (
        output i_start, i_opcode, i_zero, i_mem_ready,
        input  o_alu_op, o_alu_func, o_alu_src_b, o_pc_write, o_pc_src,
               o_ir_write, o_mem_read, o_mem_write, o_i_or_d, o_reg_write,
               o_mem_to_reg, o_halted, o_err, o_retired
    );
endinterface

// File: rtl/multicycle_main_control.sv
// rtl/multicycle_main_control.sv - multicycle datapath main control FSM with stall timeout, trap, halt and retire counter
module multicycle_main_control #(
    parameter int STALL_MAX = 15,
    parameter int CNT_W     = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    multicycle_main_control_if.slave   bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ADDR, S_MEM_RD, S_MEM_WR, S_WB_MEM,
        S_EXEC_R, S_EXEC_I, S_WB_ALU, S_BRANCH, S_HALT, S_TRAP
    } state_t;

    localparam logic [7:0] STALL_LIM = 8'(STALL_MAX);

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_stall;
    logic [CNT_W-1:0] r_retired;
    logic             w_stall_out;
    logic             w_mem_state;
    logic             w_retire;

    logic [1:0] r_alu_op;
    logic [3:0] r_alu_func;
    logic [1:0] r_alu_src_b;
    logic       r_pc_src;
    logic       r_mem_read;
    logic       r_mem_write;
    logic       r_i_or_d;
    logic       r_reg_write;
    logic       r_mem_to_reg;
    logic       r_halted;
    logic       r_err;
    logic       r_is_fetch;
    logic       r_is_branch;

    assign w_stall_out = (r_stall == STALL_LIM);
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_retire    = (w_next == S_FETCH) &&
                         ((r_state == S_MEM_WR) || (r_state == S_WB_MEM) ||
                          (r_state == S_WB_ALU) || (r_state == S_BRANCH));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.i_start) w_next = S_FETCH;
            S_FETCH: begin
                // a completing memory cycle beats the timeout on the same cycle
                if (bus.i_mem_ready)  w_next = S_DECODE;
                else if (w_stall_out) w_next = S_TRAP;
            end
            S_DECODE: begin
                case (bus.i_opcode)
                    4'b0000, 4'b0001:                     w_next = S_ADDR;
                    4'b0010, 4'b0011, 4'b0100, 4'b0101,
                    4'b0110, 4'b0111, 4'b1000, 4'b1001:   w_next = S_EXEC_R;
                    4'b1010:                              w_next = S_BRANCH;
                    4'b1011:                              w_next = S_EXEC_I;
                    4'b1111:                              w_next = S_HALT;
                    default:                              w_next = S_TRAP;
                endcase
            end
            S_ADDR:   w_next = (bus.i_opcode == 4'b0000) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (bus.i_mem_ready)  w_next = S_WB_MEM;
                else if (w_stall_out) w_next = S_TRAP;
            end
            S_MEM_WR: begin
                if (bus.i_mem_ready)  w_next = S_FETCH;
                else if (w_stall_out) w_next = S_TRAP;
            end
            S_WB_MEM: w_next = S_FETCH;
            S_EXEC_R: w_next = S_WB_ALU;
            S_EXEC_I: w_next = S_WB_ALU;
            S_WB_ALU: w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_IDLE;
        endcase
    end

    // Moore outputs are registered from the next state so they line up with r_state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_stall      <= '0;
            r_retired    <= '0;
            r_alu_op     <= 2'b00;
            r_alu_func   <= 4'b0000;
            r_alu_src_b  <= 2'b00;
            r_pc_src     <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_i_or_d     <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_halted     <= 1'b0;
            r_err        <= 1'b0;
            r_is_fetch   <= 1'b0;
            r_is_branch  <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_next != r_state)
                r_stall <= '0;
            else if (w_mem_state && !bus.i_mem_ready && !w_stall_out)
                r_stall <= r_stall + 8'd1;

            if (w_retire)
                r_retired <= r_retired + CNT_W'(1);

            r_alu_op     <= 2'b00;
            r_alu_func   <= 4'b0000;
            r_alu_src_b  <= 2'b00;
            r_pc_src     <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_i_or_d     <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_halted     <= 1'b0;
            r_err        <= 1'b0;
            r_is_fetch   <= 1'b0;
            r_is_branch  <= 1'b0;

            case (w_next)
                S_FETCH: begin
                    r_mem_read  <= 1'b1;
                    r_alu_op    <= 2'b10;
                    r_alu_src_b <= 2'b01;
                    r_is_fetch  <= 1'b1;
                end
                S_DECODE, S_ADDR, S_EXEC_I: begin
                    r_alu_op    <= 2'b10;
                    r_alu_src_b <= 2'b10;
                end
                S_MEM_RD: begin
                    r_mem_read <= 1'b1;
                    r_i_or_d   <= 1'b1;
                end
                S_MEM_WR: begin
                    r_mem_write <= 1'b1;
                    r_i_or_d    <= 1'b1;
                end
                S_WB_MEM: begin
                    r_reg_write  <= 1'b1;
                    r_mem_to_reg <= 1'b1;
                end
                S_EXEC_R: r_alu_func <= bus.i_opcode;
                S_WB_ALU: r_reg_write <= 1'b1;
                S_BRANCH: begin
                    r_alu_op    <= 2'b01;
                    r_pc_src    <= 1'b1;
                    r_is_branch <= 1'b1;
                end
                S_HALT:  r_halted <= 1'b1;
                S_TRAP:  r_err    <= 1'b1;
                default: ;
            endcase
        end
    end

    // FETCH completion and the branch PC load follow their inputs within the cycle
    assign bus.o_pc_write   = (r_is_fetch & bus.i_mem_ready) | (r_is_branch & bus.i_zero);
    assign bus.o_ir_write   = r_is_fetch & bus.i_mem_ready;
    assign bus.o_alu_op     = r_alu_op;
    assign bus.o_alu_func   = r_alu_func;
    assign bus.o_alu_src_b  = r_alu_src_b;
    assign bus.o_pc_src     = r_pc_src;
    assign bus.o_mem_read   = r_mem_read;
    assign bus.o_mem_write  = r_mem_write;
    assign bus.o_i_or_d     = r_i_or_d;
    assign bus.o_reg_write  = r_reg_write;
    assign bus.o_mem_to_reg = r_mem_to_reg;
    assign bus.o_halted     = r_halted;
    assign bus.o_err        = r_err;
    assign bus.o_retired    = r_retired;
endmodule

// File: tb/tb_multicycle_main_control.sv
// tb/tb_multicycle_main_control.sv - directed-vector bench for multicycle_main_control
module tb_multicycle_main_control;
    logic clk = 1'b0;
    logic rst_n;
    int   n_total = 0;
    int   n_bad   = 0;

    multicycle_main_control_if #(.CNT_W(16)) bus ();
    multicycle_main_control_if #(.CNT_W(4))  bus2 ();

    multicycle_main_control #(.STALL_MAX(15), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave));
    multicycle_main_control #(.STALL_MAX(15), .CNT_W(4)) dut_w (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus2.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {alu_op, alu_func, alu_src_b, pc_write, pc_src, ir_write, mem_read, mem_write,
    //  i_or_d, reg_write, mem_to_reg, halted, err}
    function automatic logic [31:0] mk(input logic [1:0] op, input logic [3:0] fn,
                                       input logic [1:0] sb, input logic [9:0] fl);
        return 32'({op, fn, sb, fl});
    endfunction

    function automatic logic [31:0] ctl();
        return 32'({bus.o_alu_op, bus.o_alu_func, bus.o_alu_src_b, bus.o_pc_write, bus.o_pc_src,
                    bus.o_ir_write, bus.o_mem_read, bus.o_mem_write, bus.o_i_or_d,
                    bus.o_reg_write, bus.o_mem_to_reg, bus.o_halted, bus.o_err});
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.i_start = 0;  bus.i_opcode = 0;  bus.i_zero = 0;  bus.i_mem_ready = 0;
        bus2.i_start = 0; bus2.i_opcode = 0; bus2.i_zero = 0; bus2.i_mem_ready = 0;
        #12;
        chk("rst_ctl", ctl(), 32'd0);
        chk("rst_ret", 32'(bus.o_retired), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // R-type with a Mealy check on FETCH completion
        bus.i_opcode = 4'b0010; bus.i_start = 1;
        step();
        bus.i_start = 0;
        #1 chk("fetch_wait", ctl(), mk(2'b10, 4'd0, 2'b01, 10'b0001000000));
        bus.i_mem_ready = 1;
        #1 chk("fetch_done", ctl(), mk(2'b10, 4'd0, 2'b01, 10'b1011000000));
        step(); chk("decode", ctl(), mk(2'b10, 4'd0, 2'b10, 10'b0));
        step(); chk("exec_r", ctl(), mk(2'b00, 4'b0010, 2'b00, 10'b0));
        step(); chk("wb_alu", ctl(), mk(2'b00, 4'd0, 2'b00, 10'b0000001000));
        step(); chk("r_ret", 32'(bus.o_retired), 32'd1);
        chk("r_fetch", ctl(), mk(2'b10, 4'd0, 2'b01, 10'b1011000000));

        // LW with three wait cycles in MEM_RD: 8 cycles FETCH to FETCH
        bus.i_opcode = 4'b0000;
        step();
        step(); chk("addr", ctl(), mk(2'b10, 4'd0, 2'b10, 10'b0));
        bus.i_mem_ready = 0;
        step(); chk("mem_rd0", ctl(), mk(2'b00, 4'd0, 2'b00, 10'b0001010000));
        for (int i = 0; i < 3; i++) begin
            step(); chk("mem_rd_wait", ctl(), mk(2'b00, 4'd0, 2'b00, 10'b0001010000));
        end
        bus.i_mem_ready = 1;
        step(); chk("wb_mem", ctl(), mk(2'b00, 4'd0, 2'b00, 10'b0000001100));
        chk("lw_ret7", 32'(bus.o_retired), 32'd1);
        step(); chk("lw_ret8", 32'(bus.o_retired), 32'd2);

        // BEQ taken then not taken
        bus.i_opcode = 4'b1010;
        step(); bus.i_zero = 1;
        step(); chk("beq_t", ctl(), mk(2'b01, 4'd0, 2'b00, 10'b1100000000));
        step(); chk("beq_t_ret", 32'(bus.o_retired), 32'd3);
        step(); bus.i_zero = 0;
        step(); chk("beq_n", ctl(), mk(2'b01, 4'd0, 2'b00, 10'b0100000000));
        step(); chk("beq_n_ret", 32'(bus.o_retired), 32'd4);

        // ADDI
        bus.i_opcode = 4'b1011;
        step();
        step(); chk("exec_i", ctl(), mk(2'b10, 4'd0, 2'b10, 10'b0));
        step(); chk("addi_wb", ctl(), mk(2'b00, 4'd0, 2'b00, 10'b0000001000));
        step(); chk("addi_ret", 32'(bus.o_retired), 32'd5);

        // SW, zero wait: 4 cycles
        bus.i_opcode = 4'b0001;
        step(); step();
        step(); chk("mem_wr", ctl(), mk(2'b00, 4'd0, 2'b00, 10'b0000110000));
        step(); chk("sw_ret", 32'(bus.o_retired), 32'd6);

        // SW aborted by reset in MEM_WR
        step(); step();
        bus.i_mem_ready = 0;
        step(); chk("mem_wr2", ctl(), mk(2'b00, 4'd0, 2'b00, 10'b0000110000));
        #1 rst_n = 1'b0;
        #1 chk("abort_ctl", ctl(), 32'd0);
        chk("abort_ret", 32'(bus.o_retired), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        bus.i_mem_ready = 1;
        step(); chk("idle_hold", ctl(), 32'd0);

        // illegal opcode
        bus.i_opcode = 4'b1101; bus.i_start = 1;
        step(); bus.i_start = 0;
        step();
        step(); chk("trap", ctl(), mk(2'b00, 4'd0, 2'b00, 10'b0000000001));
        chk("trap_ret", 32'(bus.o_retired), 32'd0);
        reset_pulse();

        // ADDI then HALT
        bus.i_opcode = 4'b1011; bus.i_start = 1;
        step(); bus.i_start = 0;
        step(); step(); step();
        step(); bus.i_opcode = 4'b1111;
        step();
        step(); chk("halt", ctl(), mk(2'b00, 4'd0, 2'b00, 10'b0000000010));
        step(); step();
        chk("halt_hold", ctl(), mk(2'b00, 4'd0, 2'b00, 10'b0000000010));
        chk("halt_ret", 32'(bus.o_retired), 32'd1);
        reset_pulse();

        // FETCH stall timeout
        bus.i_opcode = 4'b0010; bus.i_mem_ready = 0; bus.i_start = 1;
        step(); bus.i_start = 0;
        repeat (15) step();
        chk("stall_15", ctl(), mk(2'b10, 4'd0, 2'b01, 10'b0001000000));
        step(); chk("stall_trap", ctl(), mk(2'b00, 4'd0, 2'b00, 10'b0000000001));
        bus.i_start = 1; bus.i_mem_ready = 1;
        repeat (3) step();
        chk("trap_sticky", ctl(), mk(2'b00, 4'd0, 2'b00, 10'b0000000001));
        bus.i_start = 0;
        reset_pulse();

        // completion on the timeout cycle wins in MEM_RD
        bus.i_opcode = 4'b0000; bus.i_start = 1;
        step(); bus.i_start = 0;
        step(); step();
        bus.i_mem_ready = 0;
        step();
        repeat (15) step();
        chk("rd_edge", ctl(), mk(2'b00, 4'd0, 2'b00, 10'b0001010000));
        bus.i_mem_ready = 1;
        step(); chk("rd_win", ctl(), mk(2'b00, 4'd0, 2'b00, 10'b0000001100));
        step(); chk("rd_win_ret", 32'(bus.o_retired), 32'd1);

        // 4-bit counter wrap via sixteen ADDIs
        bus2.i_opcode = 4'b1011; bus2.i_mem_ready = 1; bus2.i_start = 1;
        step(); bus2.i_start = 0;
        repeat (15 * 4) step();
        chk("wrap_max", 32'(bus2.o_retired), 32'd15);
        repeat (4) step();
        chk("wrap_zero", 32'(bus2.o_retired), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle datapath; the producer of the ALU-control inputs.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the datapath enables and the {alu_op, alu_func} pair into the downstream ALU-control decoder.
- Also handles memory wait states, stall timeout, illegal-opcode trap, halt, and a retired-instruction counter.

Parameters:
STALL_MAX, 15, maximum consecutive cycles a memory state waits for mem_ready before trapping (1..255)
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  leave IDLE and begin fetching
opcode  input  4  instruction register bits [15:12]
zero  input  1  ALU zero flag (branch compare)
mem_ready  input  1  memory completes the current read/write this cycle
alu_op  output  2  10=add, 01=subtract, 00=use alu_func
alu_func  output  4  opcode forwarded to ALU control; 0000 unless alu_op=00
alu_src_b  output  2  00=reg B, 01=constant 1, 10=sign-ext immediate
pc_write  output  1  PC load enable
pc_src  output  1  0=ALU result, 1=ALUOut (branch target)
ir_write  output  1  instruction register load
mem_read  output  1  memory read request
mem_write  output  1  memory write request
i_or_d  output  1  0=PC address, 1=ALUOut address
reg_write  output  1  register file write
mem_to_reg  output  1  write-back select: 1=MDR, 0=ALUOut
halted  output  1  HALT executed (sticky)
err  output  1  illegal opcode or stall timeout (sticky)
retired  output  CNT_W  instructions completed, wraps to 0

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All 1-bit outputs 0; alu_op=00, alu_func=0000, alu_src_b=00; retired=0; stall counter=0.
  - Reset mid-instruction aborts immediately; no partial writes are issued after reset asserts.
- Output timing: outputs are decoded from the registered state. Exception: the FETCH completion enables are qualified by mem_ready (Mealy).
- ISA decode:
  - 0000 LW
  - 0001 SW
  - 0010..1001 R-type ALU
  - 1010 BEQ
  - 1011 ADDI
  - 1111 HALT
  - 1100..1110 illegal
- States and transitions:
  - IDLE: start=1 -> FETCH. start is ignored in every other state.
  - FETCH:
    - Always asserts mem_read=1, i_or_d=0, alu_op=10, alu_src_b=01.
    - On mem_ready=1, also asserts ir_write=1, pc_write=1, pc_src=0, then -> DECODE.
  - DECODE:
    - alu_op=10, alu_src_b=10 (branch target into ALUOut).
    - Branch on opcode: LW/SW -> ADDR; R-type -> EXEC_R; BEQ -> BRANCH; ADDI -> EXEC_I; HALT -> HALT; illegal -> TRAP.
  - ADDR: alu_op=10, alu_src_b=10; LW -> MEM_RD, SW -> MEM_WR.
  - MEM_RD: mem_read=1, i_or_d=1; on mem_ready -> WB_MEM.
  - MEM_WR: mem_write=1, i_or_d=1; on mem_ready -> FETCH (retires).
  - WB_MEM: reg_write=1, mem_to_reg=1 -> FETCH (retires).
  - EXEC_R: alu_op=00, alu_func=opcode, alu_src_b=00 -> WB_ALU.
  - EXEC_I: alu_op=10, alu_src_b=10 -> WB_ALU.
  - WB_ALU: reg_write=1, mem_to_reg=0 -> FETCH (retires).
  - BRANCH: alu_op=01, alu_src_b=00, pc_src=1, pc_write=zero -> FETCH (retires regardless of taken).
  - HALT: halted=1; remains until reset.
  - TRAP: err=1; remains until reset.
- Latency with zero-wait memory (mem_ready=1 on first request cycle), FETCH to FETCH: R-type 4, ADDI 4, SW 4, LW 5, BEQ 3 cycles.
- Stall timeout:
  - The stall counter clears on entry to each memory state (FETCH, MEM_RD, MEM_WR).
  - It increments each cycle that state holds with mem_ready=0.
  - If mem_ready is still 0 on the cycle the counter equals STALL_MAX -> TRAP.
  - mem_ready=1 on that same cycle completes normally (completion wins).
- mem_ready outside memory states is ignored.
- retired increments by 1 on the cycle the FSM returns to FETCH from a completing state; wraps 2^CNT_W-1 -> 0. HALT and TRAP do not increment it.

Test Plan:
- Reset, then start, then opcode=0010 (R-type), mem_ready=1 -> FETCH, DECODE, EXEC_R (alu_op=00, alu_func=0010), WB_ALU (reg_write=1); retired=1 after 4 cycles.
- LW (opcode=0000) with mem_ready held 0 for 3 cycles in MEM_RD -> mem_read, i_or_d=1 held 4 cycles; WB_MEM has mem_to_reg=1; FETCH-to-FETCH 8 cycles.
- BEQ (opcode=1010) with zero=1, then with zero=0 -> BRANCH shows alu_op=01, pc_src=1; pc_write=1 in the first case and 0 in the second; retired increments in both.
- FETCH with mem_ready never asserted, STALL_MAX=15 -> err=1 on cycle 16; further start/mem_ready have no effect; halted=0.
- opcode=1101 -> TRAP, err=1. Separately, opcode=1111 -> halted=1, retired unchanged. rst_n pulse in MEM_WR -> mem_write drops immediately, IDLE, all outputs at reset values.
- Preload retired to 16'hFFFF via 65535 ADDI instructions (or forced counter) -> next retire gives retired=0.
